// File: rtl/triangle_sweep_ctrl_if.sv
// Configuration, control and sweep-output signals of the triangle sweep controller.
// The master side configures and commands the sweep; the slave side is the controller itself.
interface triangle_sweep_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_lo;
    logic [WIDTH-1:0] cfg_hi;
    logic [WIDTH-1:0] cfg_step;
    logic [7:0]       cfg_cycles;
    logic             start;
    logic             stop;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cfg_valid, cfg_lo, cfg_hi, cfg_step, cfg_cycles, start, stop, pause,
        input  cfg_ready, count, dir, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_lo, cfg_hi, cfg_step, cfg_cycles, start, stop, pause,
        output cfg_ready, count, dir, busy, done, err
    );
endinterface

// File: rtl/triangle_sweep_ctrl.sv
// Triangle sweep generator: count ramps lo->hi->lo by step for cfg_cycles periods (0 = forever).
// Outputs registered, one edge per step; cfg accepted only in IDLE (cfg_ready), pause freezes, stop aborts.
module triangle_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    triangle_sweep_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN, PAUSED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       per_q, per_d;

    // Stored configuration (written by accepted cfg) and the copy the running sweep uses.
    logic [WIDTH-1:0] st_lo_q, st_lo_d, st_hi_q, st_hi_d, st_step_q, st_step_d;
    logic [7:0]       st_cyc_q, st_cyc_d;
    logic [WIDTH-1:0] act_lo_q, act_lo_d, act_hi_q, act_hi_d, act_step_q, act_step_d;
    logic [7:0]       act_cyc_q, act_cyc_d;

    logic             cfg_ok;
    logic [WIDTH:0]   cfg_span;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_gap;
    logic [WIDTH-1:0] dn_val;
    logic [7:0]       per_inc;

    assign cfg_span = {1'b0, bus.cfg_hi} - {1'b0, bus.cfg_lo};
    assign cfg_ok   = (bus.cfg_lo < bus.cfg_hi) && (bus.cfg_step != '0)
                      && ({1'b0, bus.cfg_step} <= cfg_span);

    // Extra carry bit keeps the rising sum from wrapping before the clamp to hi.
    assign up_sum  = {1'b0, count_q} + {1'b0, act_step_q};
    assign up_val  = (up_sum >= {1'b0, act_hi_q}) ? act_hi_q : up_sum[WIDTH-1:0];
    assign dn_gap  = count_q - act_lo_q;
    assign dn_val  = (dn_gap <= act_step_q) ? act_lo_q : (count_q - act_step_q);
    assign per_inc = per_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dir_d      = dir_q;
        per_d      = per_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        st_lo_d    = st_lo_q;
        st_hi_d    = st_hi_q;
        st_step_d  = st_step_q;
        st_cyc_d   = st_cyc_q;
        act_lo_d   = act_lo_q;
        act_hi_d   = act_hi_q;
        act_step_d = act_step_q;
        act_cyc_d  = act_cyc_q;

        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    if (cfg_ok) begin
                        st_lo_d   = bus.cfg_lo;
                        st_hi_d   = bus.cfg_hi;
                        st_step_d = bus.cfg_step;
                        st_cyc_d  = bus.cfg_cycles;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // A start launched alongside a new cfg runs on the previously stored values.
                if (bus.start) begin
                    act_lo_d   = st_lo_q;
                    act_hi_d   = st_hi_q;
                    act_step_d = st_step_q;
                    act_cyc_d  = st_cyc_q;
                    count_d    = st_lo_q;
                    dir_d      = 1'b0;
                    per_d      = 8'd0;
                    state_d    = RUN_UP;
                end
            end
            RUN_UP, RUN_DOWN, PAUSED: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    count_d = act_lo_q;
                    dir_d   = 1'b0;
                end else if (bus.pause) begin
                    state_d = PAUSED;
                end else if (!dir_q) begin
                    count_d = up_val;
                    if (up_val == act_hi_q) begin
                        state_d = RUN_DOWN;
                        dir_d   = 1'b1;
                    end else begin
                        state_d = RUN_UP;
                    end
                end else begin
                    count_d = dn_val;
                    state_d = RUN_DOWN;
                    if (dn_val == act_lo_q) begin
                        per_d = per_inc;
                        dir_d = 1'b0;
                        if ((act_cyc_q != 8'd0) && (per_inc == act_cyc_q)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN_UP;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            per_q      <= 8'd0;
            st_lo_q    <= '0;
            st_hi_q    <= '1;
            st_step_q  <= WIDTH'(1);
            st_cyc_q   <= 8'd0;
            act_lo_q   <= '0;
            act_hi_q   <= '1;
            act_step_q <= WIDTH'(1);
            act_cyc_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            per_q      <= per_d;
            st_lo_q    <= st_lo_d;
            st_hi_q    <= st_hi_d;
            st_step_q  <= st_step_d;
            st_cyc_q   <= st_cyc_d;
            act_lo_q   <= act_lo_d;
            act_hi_q   <= act_hi_d;
            act_step_q <= act_step_d;
            act_cyc_q  <= act_cyc_d;
        end
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.count     = count_q;
    assign bus.dir       = dir_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
